// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_ctrl_pkg
// Brief  : Shared types for the 5-stage pipeline sequencing controller.
// Rev    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam int REG_AW = 4;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              load;
    } slot_t;

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : hazard_scoreboard
// Brief  : Two-slot in-flight writer tracker and ID-stage hazard compare.
//          PIPE_FORWARD_EN reduces the compare to load-use against EXE only.
// Rev    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import pipe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              branch,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_two_src,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic [REG_AW-1:0] id_dest,
    output logic              hz
);

    slot_t r_s_exe;
    slot_t r_s_mem;
    logic  w_hit_exe;
    logic  w_insert;
    logic  w_unused;

    function automatic logic slot_hit(input slot_t s, input logic [REG_AW-1:0] r);
        return s.valid && (s.dest == r);
    endfunction

    assign w_hit_exe = slot_hit(r_s_exe, id_src1) || (id_two_src && slot_hit(r_s_exe, id_src2));

`ifdef PIPE_FORWARD_EN
    // Forwarding covers everything except a load result still in EXE.
    assign hz       = id_valid && r_s_exe.load && w_hit_exe;
    assign w_unused = ^r_s_mem;
`else
    logic w_hit_mem;
    assign w_hit_mem = slot_hit(r_s_mem, id_src1) || (id_two_src && slot_hit(r_s_mem, id_src2));
    assign hz        = id_valid && (w_hit_exe || w_hit_mem);
    assign w_unused  = r_s_exe.load ^ r_s_mem.load;
`endif

    assign w_insert = id_valid && id_wb_en && !hz && !branch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_exe <= '0;
            r_s_mem <= '0;
        end else if (!hold) begin
            r_s_mem <= r_s_exe;
            if (w_insert) begin
                r_s_exe <= '{valid: 1'b1, dest: id_dest, load: id_mem_r_en};
            end else begin
                r_s_exe <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl
// Brief  : Pipeline freeze/flush sequencing with memory-wait FSM, saturating
//          event counters and sticky memory timeout. Option: PIPE_FORWARD_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_two_src,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              exe_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              if_freeze,
    output logic              if_flush,
    output logic              id_flush,
    output logic              pipe_freeze,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              mem_err
);

    localparam int                  c_WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MEM_TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ERR = c_WAIT_W'(MEM_TIMEOUT - 1);

    state_t              r_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;
    logic                r_mem_err;

    logic w_mw;
    logic w_branch;
    logic w_hz_raw;
    logic w_hz;

    // Control outputs are forced quiet while reset is held, even mid-wait.
    assign w_mw     = !rst && ((r_state == RUN) ? (mem_req && !mem_ready) : !mem_ready);
    assign w_branch = !rst && !w_mw && exe_branch_taken;
    assign w_hz     = !rst && !w_mw && !exe_branch_taken && w_hz_raw;

    hazard_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .hold        (w_mw),
        .branch      (w_branch),
        .id_valid    (id_valid),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_two_src  (id_two_src),
        .id_wb_en    (id_wb_en),
        .id_mem_r_en (id_mem_r_en),
        .id_dest     (id_dest),
        .hz          (w_hz_raw)
    );

    assign pipe_freeze = w_mw;
    assign if_freeze   = w_mw || w_hz;
    assign if_flush    = w_branch;
    assign id_flush    = w_branch || w_hz;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;
    assign mem_err     = r_mem_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_mem_err   <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_wait_cnt <= '0;
                    if (mem_req && !mem_ready) begin
                        r_state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else begin
                        if (r_wait_cnt != c_WAIT_MAX) begin
                            r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                        end
                        // Set on the edge that brings the count to MEM_TIMEOUT.
                        if (r_wait_cnt == c_WAIT_ERR) begin
                            r_mem_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= RUN;
            endcase

            if ((w_mw || w_hz) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_branch && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_hazard_ctrl
// Brief  : Scoreboard bench for pipe_hazard_ctrl; expectations follow PIPE_FORWARD_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

`ifdef PIPE_FORWARD_EN
    localparam bit c_FWD = 1'b1;
`else
    localparam bit c_FWD = 1'b0;
`endif

    // Output vector order: {if_freeze, if_flush, id_flush, pipe_freeze}
    localparam logic [3:0] c_NONE = 4'b0000;
    localparam logic [3:0] c_HZ   = 4'b1010;
    localparam logic [3:0] c_BR   = 4'b0110;
    localparam logic [3:0] c_MW   = 4'b1001;
    localparam logic [3:0] c_HZ2  = c_FWD ? c_NONE : c_HZ;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_two_src, id_wb_en, id_mem_r_en;
    logic [3:0]  id_src1, id_src2, id_dest;
    logic        exe_branch_taken, mem_req, mem_ready;
    logic        if_freeze, if_flush, id_flush, pipe_freeze, mem_err;
    logic [15:0] stall_cnt, flush_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_stall = 0;
    int          exp_flush = 0;
    string       q_tag[$];
    logic [3:0]  q_exp[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_valid         (id_valid),
        .id_src1          (id_src1),
        .id_src2          (id_src2),
        .id_two_src       (id_two_src),
        .id_wb_en         (id_wb_en),
        .id_mem_r_en      (id_mem_r_en),
        .id_dest          (id_dest),
        .exe_branch_taken (exe_branch_taken),
        .mem_req          (mem_req),
        .mem_ready        (mem_ready),
        .if_freeze        (if_freeze),
        .if_flush         (if_flush),
        .id_flush         (id_flush),
        .pipe_freeze      (pipe_freeze),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt),
        .mem_err          (mem_err)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue its expected outputs.
    task automatic cyc(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic two, input logic wb, input logic ld, input logic [3:0] dst,
                       input logic br, input logic mreq, input logic mrdy,
                       input logic [3:0] exp, input string tag);
        @(negedge clk);
        id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
        id_wb_en = wb; id_mem_r_en = ld; id_dest = dst;
        exe_branch_taken = br; mem_req = mreq; mem_ready = mrdy;
        q_tag.push_back(tag);
        q_exp.push_back(exp);
        if (exp[3]) exp_stall++;
        if (exp[2]) exp_flush++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_NONE, tag);
    endtask

    task automatic check_cnts(input string tag);
        check_val({tag, "_stall"}, 32'(stall_cnt), 32'(exp_stall));
        check_val({tag, "_flush"}, 32'(flush_cnt), 32'(exp_flush));
    endtask

    // Output monitor: compares mid-cycle, well away from the rising edge.
    initial begin
        string      t;
        logic [3:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (q_exp.size() > 0) begin
                t = q_tag.pop_front();
                e = q_exp.pop_front();
                check_val(t, 32'({if_freeze, if_flush, id_flush, pipe_freeze}), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
        id_wb_en = 0; id_mem_r_en = 0; id_dest = 0;
        exe_branch_taken = 0; mem_req = 0; mem_ready = 0;
        @(posedge clk); #1;
        idle("reset_out");
        check_cnts("reset");
        check_val("reset_err", 32'(mem_err), 0);
        rst = 1'b0;

        // ALU writer followed by a dependent reader
        cyc(1, 2, 3, 1, 1, 0, 1, 0, 0, 0, c_NONE, "add_r1");
        cyc(1, 1, 5, 1, 1, 0, 4, 0, 0, 0, c_HZ2,  "sub_stall1");
        cyc(1, 1, 5, 1, 1, 0, 4, 0, 0, 0, c_HZ2,  "sub_stall2");
        cyc(1, 1, 5, 1, 1, 0, 4, 0, 0, 0, c_NONE, "sub_go");
        idle("i0"); idle("i1");
        check_cnts("alu_use");

        // Load-use through src2
        cyc(1, 2, 3, 1, 1, 1, 1, 0, 0, 0, c_NONE, "ldr_r1");
        cyc(1, 6, 1, 1, 1, 0, 4, 0, 0, 0, c_HZ,   "ldu_stall1");
        cyc(1, 6, 1, 1, 1, 0, 4, 0, 0, 0, c_HZ2,  "ldu_stall2");
        cyc(1, 6, 1, 1, 1, 0, 4, 0, 0, 0, c_NONE, "ldu_go");
        idle("i2"); idle("i3");
        check_cnts("load_use");

        // Match against the MEM slot only
        cyc(1, 0, 0, 0, 1, 0, 2, 0, 0, 0, c_NONE, "add_r2");
        cyc(1, 7, 8, 1, 1, 0, 6, 0, 0, 0, c_NONE, "indep");
        cyc(1, 2, 0, 0, 1, 0, 9, 0, 0, 0, c_HZ2,  "mem_slot_hz");
        cyc(1, 2, 0, 0, 1, 0, 9, 0, 0, 0, c_NONE, "mem_slot_go");
        idle("i4"); idle("i5");

        // src2 ignored when the instruction has one source
        cyc(1, 0, 0, 0, 1, 0, 10, 0, 0, 0, c_NONE, "add_r10");
        cyc(1, 0, 10, 0, 0, 0, 0, 0, 0, 0, c_NONE, "src2_ignored");
        idle("i6"); idle("i7");

        // Branch outranks a hazard; discarded ID instruction is not recorded
        cyc(1, 0, 0, 0, 1, 0, 3, 0, 0, 0, c_NONE, "add_r3");
        cyc(1, 3, 0, 0, 1, 0, 11, 1, 0, 0, c_BR,  "br_over_hz");
        check_cnts("branch");
        cyc(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, c_HZ2,  "br_smem_hz");
        idle("i8"); idle("i9");
        cyc(1, 0, 0, 0, 1, 0, 9, 1, 0, 0, c_BR,   "br_discard");
        cyc(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, c_NONE, "br_not_recorded");
        idle("i10"); idle("i11");

        // Five-cycle memory stall with the scoreboard held
        cyc(1, 0, 0, 0, 1, 0, 5, 0, 0, 0, c_NONE, "add_r5");
        for (int i = 0; i < 5; i++) cyc(1, 5, 0, 0, 1, 0, 12, 0, 1, 0, c_MW, "mw_stall");
        check_val("mw_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        cyc(1, 5, 0, 0, 1, 0, 12, 0, 1, 1, c_HZ2,  "mw_exit_hz");
        cyc(1, 5, 0, 0, 1, 0, 12, 0, 0, 0, c_HZ2,  "mw_exit_hz2");
        cyc(1, 5, 0, 0, 1, 0, 12, 0, 0, 0, c_NONE, "mw_go");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, c_NONE, "req_rdy_nostall");
        idle("i12"); idle("i13");
        check_cnts("mem_stall");

        // Branch deferred across a memory stall
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, c_MW, "br_deferred");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, c_BR, "br_after_mw");
        idle("i14");
        check_cnts("deferred");

        // Memory timeout
        for (int j = 1; j <= 70; j++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_MW, "to_stall");
            if (j == 64) check_val("err_before", 32'(mem_err), 0);
            if (j == 65) check_val("err_set", 32'(mem_err), 1);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, c_NONE, "to_exit");
        idle("i15");
        check_val("err_sticky", 32'(mem_err), 1);
        check_cnts("timeout");

        // Reset while in MEM_WAIT
        cyc(1, 0, 0, 0, 1, 0, 7, 0, 0, 0, c_NONE, "add_r7");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, c_MW, "pre_rst_mw");
        rst = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
        idle("rst_in_wait");
        rst = 1'b0;
        check_cnts("rst_wait");
        check_val("rst_err", 32'(mem_err), 0);
        cyc(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, c_NONE, "rst_state_run");
        idle("i16");
        check_val("queue_drained", 32'(q_exp.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
